// File: rtl/q_cmpx_stage.sv
// Bit-serial, MSB-first compare-exchange stage: each lane routes the larger word to out_hi
// and the smaller to out_lo (or the reverse when DESCEND=1) behind a one-deep output register.
//
// Lane FSM states:
//   state | meaning
//   EQ    | bits seen so far in this word are equal
//   A_GT  | A is already known to be greater; pass A to max
//   B_GT  | B is already known to be greater; pass B to max
module q_cmpx_stage #(
  parameter int LANES   = 4,
  parameter int WIDTH   = 8,
  parameter int DESCEND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_a,
  input  logic [LANES-1:0] in_b,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_hi,
  output logic [LANES-1:0] out_lo,
  output logic             out_first,
  output logic             out_last,
  output logic [LANES-1:0] swapped,
  output logic             err
);

  typedef enum logic [1:0] {
    EQ   = 2'd0,
    A_GT = 2'd1,
    B_GT = 2'd2
  } lane_state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_eff;
  logic [CW-1:0]    cnt_d;
  logic             xfer_in;
  logic             resync;
  logic             word_start;
  logic             is_last;
  logic [LANES-1:0] max_b;
  logic [LANES-1:0] min_b;
  logic [LANES-1:0] sw_d;
  lane_state_t      state_q  [LANES];
  lane_state_t      state_nx [LANES];
  lane_state_t      cur      [LANES];

  // in_ready depends only on registered out_valid and on out_ready, never on in_valid
  assign in_ready = ~out_valid | out_ready;
  assign xfer_in  = in_valid & in_ready;

  // A marker in mid-word restarts framing: the beat is evaluated as bit 0 of a fresh word
  assign resync     = in_first & (cnt_q != '0);
  assign cnt_eff    = resync ? '0 : cnt_q;
  assign word_start = (cnt_eff == '0);
  assign is_last    = (cnt_eff == LAST_CNT);
  assign cnt_d      = is_last ? '0 : cnt_eff + 1'b1;

  always_comb begin
    max_b = '0;
    min_b = '0;
    sw_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      cur[i]      = word_start ? EQ : state_q[i];
      state_nx[i] = EQ;
      case (cur[i])
        A_GT: begin
          max_b[i]    = in_a[i];
          min_b[i]    = in_b[i];
          state_nx[i] = A_GT;
        end
        B_GT: begin
          max_b[i]    = in_b[i];
          min_b[i]    = in_a[i];
          state_nx[i] = B_GT;
        end
        default: begin
          max_b[i] = in_a[i] | in_b[i];
          min_b[i] = in_a[i] & in_b[i];
          if (in_a[i] & ~in_b[i]) begin
            state_nx[i] = A_GT;
          end else if (in_b[i] & ~in_a[i]) begin
            state_nx[i] = B_GT;
          end else begin
            state_nx[i] = EQ;
          end
        end
      endcase
      sw_d[i] = is_last & (state_nx[i] == B_GT);
      if (is_last) begin
        state_nx[i] = EQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_hi    <= '0;
      out_lo    <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      swapped   <= '0;
      err       <= 1'b0;
      cnt_q     <= '0;
      state_q   <= '{default: EQ};
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_hi    <= (DESCEND != 0) ? min_b : max_b;
        out_lo    <= (DESCEND != 0) ? max_b : min_b;
        out_first <= word_start;
        out_last  <= is_last;
        swapped   <= sw_d;
        cnt_q     <= cnt_d;
        state_q   <= state_nx;
        if (resync) begin
          err <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_q_cmpx_stage.sv
// Directed bench for q_cmpx_stage: ascending and descending instances share one input stream.
module tb_q_cmpx_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_first;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_first0, out_last0, err0;
  logic [3:0] out_hi0, out_lo0, swapped0;
  logic       in_ready1, out_valid1, out_first1, out_last1, err1;
  logic [3:0] out_hi1, out_lo1, swapped1;

  q_cmpx_stage #(.LANES(4), .WIDTH(8), .DESCEND(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_first(in_first),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_hi(out_hi0), .out_lo(out_lo0), .out_first(out_first0), .out_last(out_last0),
    .swapped(swapped0), .err(err0)
  );

  q_cmpx_stage #(.LANES(4), .WIDTH(8), .DESCEND(1)) u_dut_desc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_first(in_first),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_hi(out_hi1), .out_lo(out_lo1), .out_first(out_first1), .out_last(out_last1),
    .swapped(swapped1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int stall_cnt;
  logic        err_first;
  logic [31:0] cur_a, cur_b;
  logic [31:0] got_hi0, got_lo0, got_hi1, got_lo1;
  logic [3:0]  got_sw0, got_sw1;

  // stream test storage
  logic [31:0] wa [3];
  logic [31:0] wb [3];
  logic [31:0] rh [3];
  logic [31:0] rl [3];
  logic [3:0]  rx_hi [24];
  logic [3:0]  rx_lo [24];
  logic [3:0]  rx_sw [24];
  logic [23:0] rx_first, rx_last;
  logic [3:0]  rx_sw_mid;
  logic [11:0] held;
  logic        stalled;
  int          idx, rcv, cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input int nbeats, input bit use_first);
    int k;
    for (int j = 0; j < nbeats; j++) begin
      k = 7 - j;
      for (int l = 0; l < 4; l++) begin
        in_a[l] = cur_a[l*8+k];
        in_b[l] = cur_b[l*8+k];
      end
      in_valid  = 1'b1;
      in_first  = use_first && (j == 0);
      out_ready = 1'b1;
      if (in_ready0 !== 1'b1) stall_cnt++;
      @(posedge clk);
      #1;
      for (int l = 0; l < 4; l++) begin
        got_hi0[l*8+k] = out_hi0[l];
        got_lo0[l*8+k] = out_lo0[l];
        got_hi1[l*8+k] = out_hi1[l];
        got_lo1[l*8+k] = out_lo1[l];
      end
      chk($sformatf("vld_first_last_b%0d", j), {out_valid0, out_first0, out_last0},
          {1'b1, (j == 0), (k == 0)});
      if (k == 0) begin
        got_sw0 = swapped0;
        got_sw1 = swapped1;
      end else begin
        chk($sformatf("swapped_mid_b%0d", j), {swapped1, swapped0}, 8'h00);
      end
      if (j == 0) err_first = err0;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0; out_ready = 1'b0;
    stall_cnt = 0;
    #12;
    chk("rst_state", {out_valid0, out_hi0, out_lo0, out_first0, out_last0, swapped0, err0}, '0);
    chk("rst_in_ready", {in_ready0, in_ready1}, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // mixed lanes: A>B, A==B, B>A, B>A
    cur_a = 32'h00123CA5;
    cur_b = 32'hFF803C5A;
    send_word(8, 1'b1);
    chk("w1_hi_asc", got_hi0, 32'hFF803CA5);
    chk("w1_lo_asc", got_lo0, 32'h00123C5A);
    chk("w1_sw_asc", got_sw0, 4'b1100);
    chk("w1_hi_desc", got_hi1, 32'h00123C5A);
    chk("w1_lo_desc", got_lo1, 32'hFF803CA5);
    chk("w1_sw_desc", got_sw1, 4'b1100);
    chk("w1_no_stall", stall_cnt, 0);
    chk("w1_err", err0, 1'b0);
    // word start without in_first marker
    send_word(8, 1'b0);
    chk("w2_hi", got_hi0, 32'hFF803CA5);
    chk("w2_lo", got_lo0, 32'h00123C5A);
    chk("w2_err", {err1, err0}, 2'b00);
    @(posedge clk);
    #1;
    chk("idle_valid_clear", {out_valid0, in_ready0}, 2'b01);

    // three back-to-back words with out_ready toggling 1,0,1,0
    wa[0] = 32'h557F01F0; wb[0] = 32'h5580020F;
    wa[1] = 32'hC381FE00; wb[1] = 32'h3C80FF01;
    wa[2] = 32'hFF120080; wb[2] = 32'hFE340000;
    idx = 0; rcv = 0; cyc = 0;
    rx_first = '0; rx_last = '0; rx_sw_mid = '0;
    while (rcv < 24 && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = (idx < 24);
      in_first  = (idx < 24) && (idx % 8 == 0);
      if (idx < 24) begin
        for (int l = 0; l < 4; l++) begin
          in_a[l] = wa[idx/8][l*8 + 7 - idx%8];
          in_b[l] = wb[idx/8][l*8 + 7 - idx%8];
        end
      end
      @(negedge clk);
      if (out_valid0 && out_ready) begin
        rx_hi[rcv]    = out_hi0;
        rx_lo[rcv]    = out_lo0;
        rx_sw[rcv]    = swapped0;
        rx_first[rcv] = out_first0;
        rx_last[rcv]  = out_last0;
        rcv++;
      end
      stalled = out_valid0 && !out_ready;
      held    = {out_valid0, out_hi0, out_lo0, out_first0, out_last0, swapped0[0]};
      if (in_valid && in_ready0) idx++;
      @(posedge clk);
      #1;
      if (stalled)
        chk($sformatf("stall_hold_c%0d", cyc),
            {out_valid0, out_hi0, out_lo0, out_first0, out_last0, swapped0[0]}, held);
      cyc++;
    end
    in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
    chk("stream_beats", rcv, 24);
    for (int r = 0; r < 24; r++) begin
      for (int l = 0; l < 4; l++) begin
        rh[r/8][l*8 + 7 - r%8] = rx_hi[r][l];
        rl[r/8][l*8 + 7 - r%8] = rx_lo[r][l];
      end
      if (r % 8 != 7) rx_sw_mid = rx_sw_mid | rx_sw[r];
    end
    chk("s0_hi", rh[0], 32'h558002F0);
    chk("s0_lo", rl[0], 32'h557F010F);
    chk("s1_hi", rh[1], 32'hC381FF01);
    chk("s1_lo", rl[1], 32'h3C80FE00);
    chk("s2_hi", rh[2], 32'hFF340080);
    chk("s2_lo", rl[2], 32'hFE120000);
    chk("s_sw", {rx_sw[23], rx_sw[15], rx_sw[7]}, {4'b0100, 4'b0011, 4'b0110});
    chk("s_sw_mid", rx_sw_mid, 4'b0000);
    chk("s_first", rx_first, 24'h010101);
    chk("s_last", rx_last, 24'h808080);

    // in_first at beat 3 of a word forces a resync
    cur_a = 32'hFFFFFFFF;
    cur_b = 32'h00000000;
    send_word(3, 1'b1);
    chk("pre_resync_err", err0, 1'b0);
    cur_a = 32'hFF120080;
    cur_b = 32'hFE340000;
    send_word(8, 1'b1);
    chk("resync_err_set", err_first, 1'b1);
    chk("resync_hi", got_hi0, 32'hFF340080);
    chk("resync_lo", got_lo0, 32'hFE120000);
    chk("resync_sw", got_sw0, 4'b0100);
    cur_a = 32'hC381FE00;
    cur_b = 32'h3C80FF01;
    send_word(8, 1'b1);
    chk("post_resync_hi", got_hi0, 32'hC381FF01);
    chk("post_resync_lo", got_lo0, 32'h3C80FE00);
    chk("post_resync_sw", got_sw0, 4'b0011);
    chk("err_sticky", {err1, err0}, 2'b11);

    // reset after beat 5 of a word
    cur_a = 32'h12345678;
    cur_b = 32'h87654321;
    send_word(5, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {out_valid0, out_first0, out_last0, swapped0, err0, out_hi0, out_lo0}, '0);
    chk("rst_ready", in_ready0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_valid", {out_valid0, out_valid1}, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cur_a = 32'hFFFFFFFF;
    cur_b = 32'h00000000;
    send_word(8, 1'b1);
    chk("after_rst_hi", got_hi0, 32'hFFFFFFFF);
    chk("after_rst_lo", got_lo0, 32'h00000000);
    chk("after_rst_sw", got_sw0, 4'b0000);
    chk("after_rst_err", err0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/q_cmpx_stage.md
Q_CMPX_STAGE -- requirements
Module: q_cmpx_stage

Interface
REQ-001 Parameter LANES, default 4, number of independent bit-serial compare-exchange lanes (1..32).
REQ-002 Parameter WIDTH, default 8, word length in bits per lane (2..64).
REQ-003 Parameter DESCEND, default 0, output order: 0 means out_hi carries max and out_lo carries min; 1 means the ports are exchanged.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_ready  output  1  stage can accept a beat.
REQ-008 in_a  input  LANES  operand A bit per lane, MSB first.
REQ-009 in_b  input  LANES  operand B bit per lane, MSB first.
REQ-010 in_first  input  1  beat carries bit WIDTH-1 (MSB) of a new word.
REQ-011 out_valid  output  1  downstream beat valid.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_hi, out_lo  output  LANES each  exchanged serial bits per lane.
REQ-014 out_first, out_last  output  1 each  beat is MSB / LSB of word.
REQ-015 swapped  output  LANES  per lane, 1 when B>A strictly; meaningful only on out_last beats, 0 otherwise.
REQ-016 err  output  1  sticky framing-error flag.

Function
REQ-017 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; lane state, bit counter and output register change only on transfer in, except out_valid clear.
REQ-018 in_ready SHALL equal ~out_valid | out_ready (single output register, full throughput, no combinational path from in_valid to in_ready).
REQ-019 Latency SHALL be exactly 1 cycle: a beat accepted at edge N is presented on out_* after edge N.
REQ-020 out_valid SHALL set on transfer in, clear on transfer out without transfer in, and hold otherwise; out_* SHALL be stable while out_valid & ~out_ready.
REQ-021 Bit counter SHALL count accepted beats 0..WIDTH-1 and wrap to 0; out_first = (count==0) and out_last = (count==WIDTH-1) for the registered beat.
REQ-022 in_first with counter 0 is a normal word start; in_first with counter != 0 SHALL force counter to 0, all lanes to EQ before evaluating the beat, and set err.
REQ-023 in_first low while counter == 0 SHALL be accepted as a word start without error (in_first is a resync marker, not mandatory).
REQ-024 Per-lane FSM states EQ, A_GT, B_GT; EQ on word start.
REQ-025 EQ: a==b -> max=min=a, stay EQ; a=1,b=0 -> max=1,min=0, go A_GT; a=0,b=1 -> max=1,min=0, go B_GT.
REQ-026 A_GT: max=a, min=b, stay; B_GT: max=b, min=a, stay; lanes are mutually independent.
REQ-027 After the LSB beat every lane SHALL return to EQ; swapped[i] on that beat = 1 iff lane i went to B_GT during the word (including the LSB beat itself).
REQ-028 Simultaneous transfer in and out SHALL replace the output register with no bubble and no lost beat.

Reset
REQ-029 rst low SHALL immediately clear out_valid, out_hi, out_lo, out_first, out_last, swapped, err, counter to 0 and all lanes to EQ, regardless of clk.
REQ-030 in_ready SHALL read 1 during and after reset; reset mid-word discards the partial word with no err.
REQ-031 err SHALL clear only on reset.

Verification
REQ-032 LANES=4,WIDTH=8,DESCEND=0; lane0 A=0xA5,B=0x5A; lane1 A=B=0x3C -> lane0 hi=0xA5, lo=0x5A, swapped=0; lane1 hi=lo=0x3C, swapped=0.
REQ-033 Lane2 A=0x12,B=0x80 with DESCEND=1 -> out_hi serializes 0x12, out_lo 0x80, swapped[2]=1 on out_last beat.
REQ-034 Back-to-back 3 words, out_ready toggling 1,0,1,0 -> every beat delivered once in order, out_* stable when stalled, word throughput 8 beats when out_ready held 1.
REQ-035 in_first pulsed at beat 3 of a word -> err=1 from next cycle, counter restarts, following word compared correctly, err remains 1.
REQ-036 rst asserted at beat 5 then released; next word A=0xFF,B=0x00 -> out_valid 0 during reset, result hi=0xFF, lo=0x00, err=0.
